// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous square wave in reference-clock ticks,
// with a per-period valid strobe and a sticky loss-of-activity timeout.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | disarmed; waiting for a rising edge (with enable) to arm
//   MEASURE | armed; each rising edge publishes the period just completed
module clk_period_meter #(
    parameter int CTR_W       = 27,
    parameter int TIMEOUT     = 100_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             incoming_CLK100MHZ,
    input  logic             incoming_RSTN,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CTR_W-1:0] period_cycles,
    output logic [CTR_W-1:0] high_cycles,
    output logic             meas_valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MEASURE = 1'b1;

    localparam logic [CTR_W-1:0] TO_LAST = CTR_W'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;
    logic                   s;
    logic                   rise;
    logic                   fall;
    logic [CTR_W-1:0]       ctr;
    logic [CTR_W-1:0]       ctr_p1;
    logic [CTR_W-1:0]       ctr_sat;
    logic [CTR_W-1:0]       hi_tmp;
    logic [0:0]             state;

    assign s       = sync_q[SYNC_STAGES-1];
    assign rise    = s & ~s_d;
    assign fall    = ~s & s_d;
    assign ctr_p1  = ctr + CTR_W'(1);
    // Saturate so an overlong period can never wrap into a plausible small value.
    assign ctr_sat = (ctr == {CTR_W{1'b1}}) ? ctr : ctr_p1;
    assign busy    = (state == MEASURE);

    always_ff @(posedge incoming_CLK100MHZ or negedge incoming_RSTN) begin
        if (!incoming_RSTN) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= s;
        end
    end

    always_ff @(posedge incoming_CLK100MHZ or negedge incoming_RSTN) begin
        if (!incoming_RSTN) begin
            state         <= IDLE;
            ctr           <= '0;
            hi_tmp        <= '0;
            period_cycles <= '0;
            high_cycles   <= '0;
            meas_valid    <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!enable) begin
                state  <= IDLE;
                ctr    <= '0;
                hi_tmp <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        ctr <= '0;
                        if (rise) state <= MEASURE;
                    end
                    MEASURE: begin
                        // A rise on the terminal-count cycle is still a valid measurement.
                        if (rise) begin
                            period_cycles <= ctr_p1;
                            high_cycles   <= hi_tmp;
                            meas_valid    <= 1'b1;
                            timeout       <= 1'b0;
                            ctr           <= '0;
                        end else if (ctr == TO_LAST) begin
                            timeout <= 1'b1;
                            state   <= IDLE;
                            ctr     <= '0;
                        end else begin
                            ctr <= ctr_sat;
                            if (fall) hi_tmp <= ctr_p1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        ctr   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: square waves of known period/duty, timeout,
// enable gating and asynchronous reset, checked with immediate assertions.
module tb_clk_period_meter;

    localparam int CTR_W   = 27;
    localparam int TIMEOUT = 1000;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             sig_in = 1'b0;
    logic             enable = 1'b0;
    logic [CTR_W-1:0] period_cycles;
    logic [CTR_W-1:0] high_cycles;
    logic             meas_valid;
    logic             timeout;
    logic             busy;

    int errors = 0;
    int checks = 0;

    int sq_period = 10;
    int sq_high   = 5;
    int phase     = 0;
    bit sq_on     = 1'b0;

    clk_period_meter #(
        .CTR_W      (CTR_W),
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(2)
    ) dut (
        .incoming_CLK100MHZ(clk),
        .incoming_RSTN     (rst_n),
        .sig_in            (sig_in),
        .enable            (enable),
        .period_cycles     (period_cycles),
        .high_cycles       (high_cycles),
        .meas_valid        (meas_valid),
        .timeout           (timeout),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Square-wave source, updated on falling edges so it is stable at the sampling edge.
    initial forever begin
        @(negedge clk);
        if (sq_on) begin
            sig_in = (phase < sq_high);
            phase  = (phase + 1 >= sq_period) ? 0 : phase + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_wave(input int p, input int h);
        sq_period = p;
        sq_high   = h;
        phase     = 0;
        sq_on     = 1'b1;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!meas_valid && n < max);
        check("wait_valid_bound", 32'(meas_valid), 1);
    endtask

    initial begin
        int n;
        int cnt;

        repeat (3) @(negedge clk);
        check("rst_period", period_cycles, 0);
        check("rst_high", high_cycles, 0);
        check("rst_valid", 32'(meas_valid), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_busy", 32'(busy), 0);

        // 100-tick square, 50% duty
        rst_n  = 1'b1;
        enable = 1'b1;
        start_wave(100, 50);
        wait_valid(400, n);
        check("first_valid_after_second_rise", 32'(n > 100), 1);
        check("p100_period", period_cycles, 100);
        check("p100_high", high_cycles, 50);
        check("p100_busy", 32'(busy), 1);
        @(negedge clk);
        check("valid_one_cycle", 32'(meas_valid), 0);
        wait_valid(200, n);
        check("p100_interval", n + 1, 100);
        check("p100_period2", period_cycles, 100);

        // fastest input: toggles every clock
        start_wave(2, 1);
        repeat (3) wait_valid(50, n);
        wait_valid(50, n);
        check("p2_interval", n, 2);
        check("p2_period", period_cycles, 2);
        check("p2_high", high_cycles, 1);

        // asymmetric: 3 high, 7 low
        start_wave(10, 3);
        repeat (3) wait_valid(50, n);
        wait_valid(50, n);
        check("p10_interval", n, 10);
        check("p10_period", period_cycles, 10);
        check("p10_high", high_cycles, 3);

        // stop the input right after a rise; timeout must land TIMEOUT ticks later
        wait_valid(50, n);
        sq_on = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!timeout && n < 1500);
        check("timeout_set", 32'(timeout), 1);
        check("timeout_latency", n, TIMEOUT);
        check("timeout_idle", 32'(busy), 0);
        check("timeout_hold_period", period_cycles, 10);
        check("timeout_hold_high", high_cycles, 3);
        repeat (200) @(negedge clk);
        check("timeout_sticky", 32'(timeout), 1);

        // recovery: first rise arms, the next one measures and clears timeout
        start_wave(200, 100);
        wait_valid(600, n);
        check("recover_arm_only", 32'(n > 200), 1);
        check("recover_timeout_clr", 32'(timeout), 0);
        check("recover_period", period_cycles, 200);
        check("recover_high", high_cycles, 100);

        // enable gating
        start_wave(400, 200);
        repeat (2) wait_valid(900, n);
        check("p400_period", period_cycles, 400);
        check("p400_high", high_cycles, 200);
        repeat (100) @(negedge clk);
        enable = 1'b0;
        cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (meas_valid) cnt++;
        end
        check("dis_no_valid", cnt, 0);
        check("dis_hold_period", period_cycles, 400);
        check("dis_hold_high", high_cycles, 200);
        check("dis_busy", 32'(busy), 0);
        check("dis_timeout", 32'(timeout), 0);
        enable = 1'b1;
        wait_valid(1200, n);
        check("reen_arm_only", 32'(n > 400), 1);
        check("reen_period", period_cycles, 400);
        check("reen_high", high_cycles, 200);

        // asynchronous reset mid-period, asserted between clock edges during the low half
        repeat (250) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_period", period_cycles, 0);
        check("arst_high", high_cycles, 0);
        check("arst_valid", 32'(meas_valid), 0);
        check("arst_timeout", 32'(timeout), 0);
        check("arst_busy", 32'(busy), 0);
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        wait_valid(1200, n);
        check("post_rst_arm_only", 32'(n > 400), 1);
        check("post_rst_period", period_cycles, 400);
        check("post_rst_high", high_cycles, 200);
        check("post_rst_busy", 32'(busy), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
